// File: rtl/key_debouncer_pkg.sv
// key_debouncer_pkg: shared constants and helpers for the key debouncer.
package key_debouncer_pkg;
  localparam int DEFAULT_CNT_MAX = 500000;
  function automatic int cnt_width(input int max);
    return $clog2(max);
  endfunction
endpackage

// File: rtl/key_debouncer_if.sv
// key_debouncer_if: board-input / parallel-port bundle; slave is the debouncer side.
interface key_debouncer_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] stable_out;
  logic [WIDTH-1:0] press_pulse;
  logic [WIDTH-1:0] release_pulse;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] edge_clear;
  logic             irq;
  modport master (output raw_in, edge_clear, input stable_out, press_pulse, release_pulse, edge_capture, irq);
  modport slave (input raw_in, edge_clear, output stable_out, press_pulse, release_pulse, edge_capture, irq);
endinterface

// File: rtl/key_debouncer_channel.sv
// debounce_channel: 2-FF synchroniser, stability counter, debounced level and edge strobes.
module debounce_channel
  import key_debouncer_pkg::*;
#(
  parameter int CNT_MAX    = DEFAULT_CNT_MAX,
  parameter int ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic press_pulse,
  output logic release_pulse,
  output logic press_set
);
  localparam int CW = cnt_width(CNT_MAX);
  localparam logic [CW-1:0] LAST = CW'(CNT_MAX - 1);
  localparam logic INV = (ACTIVE_LOW != 0);
  logic sync1, sync2, fire;
  logic [CW-1:0] cnt;
  assign fire = (sync2 != stable) && (cnt == LAST);
  assign press_set = fire & sync2;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1         <= 1'b0;
      sync2         <= 1'b0;
      stable        <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      cnt           <= '0;
    end else begin
      sync1         <= raw ^ INV;
      sync2         <= sync1;
      cnt           <= (sync2 == stable || fire) ? '0 : cnt + 1'b1;
      stable        <= fire ? sync2 : stable;
      press_pulse   <= fire & sync2;
      release_pulse <= fire & ~sync2;
    end
  end
endmodule

// File: rtl/key_debouncer.sv
// key_debouncer: WIDTH debounced channels; sticky press capture + irq when DEBOUNCE_EDGE_CAPTURE_EN is defined.
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int CNT_MAX    = DEFAULT_CNT_MAX,
  parameter int ACTIVE_LOW = 1
) (
  input logic          clk,
  input logic          reset,
  key_debouncer_if.slave bus
);
  logic [WIDTH-1:0] stable, press, rel, press_set;
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(.CNT_MAX(CNT_MAX), .ACTIVE_LOW(ACTIVE_LOW)) u_ch (
      .clk(clk),
      .reset(reset),
      .raw(bus.raw_in[i]),
      .stable(stable[i]),
      .press_pulse(press[i]),
      .release_pulse(rel[i]),
      .press_set(press_set[i])
    );
  end
  assign bus.stable_out    = stable;
  assign bus.press_pulse   = press;
  assign bus.release_pulse = rel;
`ifdef DEBOUNCE_EDGE_CAPTURE_EN
  logic [WIDTH-1:0] ec;
  // set uses the pre-edge press decision so capture lands with stable_out; set beats clear
  always_ff @(posedge clk) begin
    if (reset) ec <= '0;
    else ec <= press_set | (ec & ~bus.edge_clear);
  end
  assign bus.edge_capture = ec;
  assign bus.irq = |ec;
`else
  logic unused;
  assign unused = ^{bus.edge_clear, press_set};
  assign bus.edge_capture = '0;
  assign bus.irq = 1'b0;
`endif
endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer: directed + random stimulus against a sliding-window reference model.
module tb_key_debouncer;
  localparam int W  = 4;
  localparam int CM = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  key_debouncer_if #(.WIDTH(W)) bus ();
  key_debouncer #(.WIDTH(W), .CNT_MAX(CM), .ACTIVE_LOW(1)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] hist[$];
  logic [W-1:0] m_stable = '0, m_press = '0, m_rel = '0, m_ec = '0;
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic tick();
    logic [W-1:0] n;
    bit all_diff;
    @(posedge clk);
    n = reset ? '0 : ~bus.raw_in;
    if (reset) begin
      hist = {};
      for (int k = 0; k < CM + 2; k++) hist.push_front('0);
      m_stable = '0; m_press = '0; m_rel = '0; m_ec = '0;
    end else begin
      hist.push_front(n);
      void'(hist.pop_back());
      m_press = '0; m_rel = '0;
      for (int c = 0; c < W; c++) begin
        all_diff = 1'b1;
        for (int k = 2; k < CM + 2; k++) if (hist[k][c] == m_stable[c]) all_diff = 1'b0;
        if (all_diff) begin
          m_stable[c] = ~m_stable[c];
          m_press[c] = m_stable[c];
          m_rel[c] = ~m_stable[c];
        end
      end
`ifdef DEBOUNCE_EDGE_CAPTURE_EN
      m_ec = m_press | (m_ec & ~bus.edge_clear);
`endif
    end
    #1;
    chk("stable_out", bus.stable_out, m_stable);
    chk("press_pulse", bus.press_pulse, m_press);
    chk("release_pulse", bus.release_pulse, m_rel);
    chk("edge_capture", bus.edge_capture, m_ec);
    chk("irq", {3'b0, bus.irq}, {3'b0, |m_ec});
  endtask
  task automatic ticks(input int k);
    for (int j = 0; j < k; j++) tick();
  endtask
  initial begin
    bus.raw_in = 4'b1111;
    bus.edge_clear = '0;
    ticks(3);
    chk("reset_all_zero", bus.stable_out | bus.press_pulse | bus.release_pulse, 4'b0);
    reset = 1'b0;
    ticks(12);
    chk("released_idle", bus.stable_out, 4'b0);
    bus.raw_in[0] = 1'b0;
    ticks(5);
    chk("k0_no_press_edge5", {3'b0, bus.press_pulse[0]}, 4'b0);
    tick();
    chk("k0_press_edge6", bus.press_pulse, 4'b0001);
    chk("k0_stable_edge6", bus.stable_out, 4'b0001);
    tick();
    chk("k0_press_one_cycle", {3'b0, bus.press_pulse[0]}, 4'b0);
    bus.raw_in[1] = 1'b0;
    ticks(3);
    bus.raw_in[1] = 1'b1;
    ticks(8);
    chk("k1_glitch_filtered", {3'b0, bus.stable_out[1]}, 4'b0);
    bus.raw_in[2] = 1'b0;
    ticks(2);
    bus.raw_in[2] = 1'b1;
    tick();
    bus.raw_in[2] = 1'b0;
    ticks(5);
    chk("k2_bounce_no_press_edge5", {3'b0, bus.press_pulse[2]}, 4'b0);
    tick();
    chk("k2_bounce_press_edge6", {3'b0, bus.press_pulse[2]}, 4'b1);
    bus.edge_clear = 4'b1111;
    tick();
    bus.edge_clear = '0;
    bus.raw_in[3] = 1'b0;
    ticks(6);
    chk("k3_press", {3'b0, bus.press_pulse[3]}, 4'b1);
`ifdef DEBOUNCE_EDGE_CAPTURE_EN
    chk("k3_capture_set", {3'b0, bus.edge_capture[3]}, 4'b1);
    chk("k3_irq_set", {3'b0, bus.irq}, 4'b1);
`endif
    ticks(4);
    bus.raw_in[3] = 1'b1;
    ticks(5);
    chk("k3_no_release_early", {3'b0, bus.release_pulse[3]}, 4'b0);
    tick();
    chk("k3_release_10_after", {3'b0, bus.release_pulse[3]}, 4'b1);
    bus.edge_clear[3] = 1'b1;
    tick();
    bus.edge_clear[3] = 1'b0;
    chk("k3_capture_cleared", {3'b0, bus.edge_capture[3]}, 4'b0);
    bus.raw_in[3] = 1'b0;
    ticks(5);
    bus.edge_clear[3] = 1'b1;
    tick();
    bus.edge_clear[3] = 1'b0;
`ifdef DEBOUNCE_EDGE_CAPTURE_EN
    chk("k3_set_beats_clear", {3'b0, bus.edge_capture[3]}, 4'b1);
`else
    chk("k3_capture_tied_low", bus.edge_capture, 4'b0);
`endif
    bus.raw_in = 4'b1111;
    ticks(10);
    chk("all_released", bus.stable_out, 4'b0);
    bus.raw_in[0] = 1'b0;
    ticks(4);
    reset = 1'b1;
    ticks(2);
    chk("reset_mid_window", bus.press_pulse | bus.stable_out, 4'b0);
    reset = 1'b0;
    ticks(5);
    chk("post_reset_no_press_edge5", {3'b0, bus.press_pulse[0]}, 4'b0);
    tick();
    chk("post_reset_press_edge6", {3'b0, bus.press_pulse[0]}, 4'b1);
    for (int r = 0; r < 400; r++) begin
      if ($urandom_range(3) == 0) bus.raw_in[$urandom_range(W - 1)] ^= 1'b1;
      bus.edge_clear = ($urandom_range(5) == 0) ? 4'($urandom) : '0;
      reset = ($urandom_range(150) == 0);
      tick();
    end
    reset = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/key_debouncer.md
# key_debouncer

Multi-channel debouncer between the board pushbuttons/slider switches and the system's parallel-port inputs. Each raw mechanical input is synchronised to the system clock and filtered until stable for a programmable number of cycles. The block then drives a clean level plus single-cycle press and release strobes. An optional sticky edge-capture register with an interrupt line is compiled in by macro.

## Interface
Parameters:
- WIDTH, 4: number of independent channels.
- CNT_MAX, 500000: stability window in clock cycles (10 ms at 50 MHz); legal range ≥ 2.
- ACTIVE_LOW, 1: when 1, raw_in is inverted on entry, so a pressed KEY reads as 1 internally and on all outputs.

Ports (one clock; reset is synchronous and active-high):
- clk, in, 1: system clock (50 MHz domain).
- reset, in, 1: synchronous, active-high; sampled only on the rising edge of clk.
- raw_in, in, WIDTH: asynchronous raw board inputs (KEY / SW).
- stable_out, out, WIDTH: debounced level, 1 = asserted/pressed.
- press_pulse, out, WIDTH: one-cycle strobe on a debounced 0→1 transition.
- release_pulse, out, WIDTH: one-cycle strobe on a debounced 1→0 transition.
- edge_capture, out, WIDTH: sticky press flags (macro-dependent).
- edge_clear, in, WIDTH: per-bit clear for edge_capture, 1 = clear.
- irq, out, 1: OR of edge_capture.

## Operation
- Per channel: normalise the input (invert if ACTIVE_LOW), then pass it through a 2-FF synchroniser (sync1 → sync2).
- Counter cnt has width $clog2(CNT_MAX), unsigned. On each edge:
  - If sync2 == stable: cnt ← 0.
  - Else if cnt == CNT_MAX−1: stable ← sync2, cnt ← 0, and the matching pulse is asserted.
  - Else: cnt ← cnt+1.
- Any single cycle where sync2 returns to the stable level restarts the window from 0. A glitch shorter than CNT_MAX cycles never reaches stable_out.
- Channels are fully independent. Simultaneous transitions on several channels are processed in parallel.
- press_pulse and release_pulse are registered. They are never both high on one channel, and are never high on consecutive cycles for the same channel.
- Reset values:
  - sync1, sync2, stable_out, press_pulse, release_pulse, cnt, edge_capture, irq = 0.
  - A key held through reset therefore produces press_pulse one full latency after reset deasserts.
- Reset asserted mid-window discards the count. No pulse is generated.

## Timing
- Number the first clk edge that samples a new raw_in value as edge 1.
- stable_out and the pulse update on edge CNT_MAX+2, so they are visible for the cycle after that edge.
- The pulse is high for exactly one cycle, concurrent with the first cycle of the new stable_out.
- edge_capture sets on the same edge as stable_out; irq follows combinationally from edge_capture.
- No combinational path from raw_in to any output.

## Configuration
- DEBOUNCE_EDGE_CAPTURE_EN defined:
  - edge_capture[i] ← 1 on press_pulse[i].
  - edge_capture[i] ← 0 on edge_clear[i].
  - If set and clear occur in the same cycle, set wins.
  - irq = |edge_capture.
- Undefined: edge_capture and irq are tied to 0, and edge_clear is ignored. The ports remain present, so the top-level wiring is identical in both builds.

## Structure
- Package key_debouncer_pkg holds:
  - constant DEFAULT_CNT_MAX = 500000
  - function cnt_width(max) returning $clog2(max)
- Sub-module debounce_channel (synchroniser, counter, stable register, pulse generation) is instantiated WIDTH times by a generate loop.
- Edge capture and irq live in key_debouncer.

## Test plan
Simulate with CNT_MAX=4, WIDTH=4, ACTIVE_LOW=1.
- Reset → all outputs 0. Then raw_in=4'b1111 (released) held → outputs stay 0 indefinitely.
- raw_in[0] 1→0 held → stable_out[0]=1 and press_pulse[0]=1 for one cycle at edge 6. Other bits stay 0.
- raw_in[1] low for 3 cycles, then high → stable_out[1], press_pulse[1] and release_pulse[1] all stay 0.
- Bounce on raw_in[2]: low 2, high 1, low held → window restarts, press_pulse[2] at edge 6 counted from the final low.
- Key 3 pressed then released after 10 cycles → press_pulse[3], then release_pulse[3] exactly 10 cycles later. With the macro, edge_capture[3]=1 and irq=1 until edge_clear[3]; a clear coinciding with a new press leaves the bit at 1.
- Reset asserted at count 2 with raw_in[0] low → cnt cleared, no pulse during reset. press_pulse[0] arrives 6 edges after reset deasserts.
